// File: rtl/ats21_host.sv
// Host-side initiator for the ATS21 request interface: command FIFO, single
// outstanding transaction with busy retry and timeout, plus sticky alarm flags.
module ats21_host #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  output logic        rsp_valid,
  output logic [1:0]  rsp_stat,
  output logic        rsp_timeout,
  output logic        busy,
  output logic        req,
  output logic [15:0] ctrlA,
  output logic [15:0] ctrlB,
  input  logic        ready,
  input  logic [1:0]  stat,
  input  logic [23:0] data,
  output logic [23:0] alarm_pending,
  input  logic [23:0] alarm_clear,
  output logic        alarm_irq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [1:0] STAT_OK   = 2'b00;
  localparam logic [1:0] STAT_BUSY = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_GAP} state_e;

  state_e        state_q, state_d;
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [31:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          retry_pend_q, retry_pend_d;
  logic          req_q, req_d;
  logic [15:0]   ctrla_q, ctrla_d;
  logic [15:0]   ctrlb_q, ctrlb_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [1:0]    rsp_stat_q, rsp_stat_d;
  logic          rsp_timeout_q, rsp_timeout_d;
  logic          busy_q, busy_d;
  logic [23:0]   data_q, data_d;
  logic [23:0]   pending_q, pending_d;
  logic          fifo_empty, fifo_full, push, pop;

  always_comb begin
    fifo_empty = (cnt_q == '0);
    fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
    // A full FIFO in IDLE is always popped this cycle, so the slot is free.
    cmd_ready  = !fifo_full || (state_q == ST_IDLE);
    pop        = (state_q == ST_IDLE) && !fifo_empty;
    push       = cmd_valid && cmd_ready;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = {cmd_a, cmd_b};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    cnt_d = cnt_q + CW'(push) - CW'(pop);

    state_d       = state_q;
    ctrla_d       = ctrla_q;
    ctrlb_d       = ctrlb_q;
    tmo_d         = tmo_q;
    retry_d       = retry_q;
    retry_pend_d  = retry_pend_q;
    rsp_valid_d   = 1'b0;
    rsp_stat_d    = rsp_stat_q;
    rsp_timeout_d = rsp_timeout_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pop) begin
          {ctrla_d, ctrlb_d} = mem_q[rd_ptr_q];
          tmo_d              = '0;
          retry_d            = '0;
          retry_pend_d       = 1'b0;
          state_d            = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ready) begin
          state_d = ST_GAP;
          if ((stat == STAT_BUSY) && (retry_q < RW'(MAX_RETRY))) begin
            retry_d      = retry_q + RW'(1);
            retry_pend_d = 1'b1;
          end else begin
            rsp_valid_d   = 1'b1;
            rsp_stat_d    = stat;
            rsp_timeout_d = 1'b0;
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d       = ST_GAP;
          rsp_valid_d   = 1'b1;
          rsp_stat_d    = STAT_OK;
          rsp_timeout_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_GAP: begin
        if (retry_pend_q) begin
          retry_pend_d = 1'b0;
          tmo_d        = '0;
          state_d      = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    req_d     = (state_d == ST_REQ);
    busy_d    = (state_d != ST_IDLE) || (cnt_d != '0);
    data_d    = data;
    pending_d = (pending_q & ~alarm_clear) | (data & ~data_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      tmo_q         <= '0;
      retry_q       <= '0;
      retry_pend_q  <= 1'b0;
      req_q         <= 1'b0;
      ctrla_q       <= '0;
      ctrlb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_stat_q    <= '0;
      rsp_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      data_q        <= '0;
      pending_q     <= '0;
    end else begin
      state_q       <= state_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      retry_q       <= retry_d;
      retry_pend_q  <= retry_pend_d;
      req_q         <= req_d;
      ctrla_q       <= ctrla_d;
      ctrlb_q       <= ctrlb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_stat_q    <= rsp_stat_d;
      rsp_timeout_q <= rsp_timeout_d;
      busy_q        <= busy_d;
      data_q        <= data_d;
      pending_q     <= pending_d;
    end
  end

  assign req           = req_q;
  assign ctrlA         = ctrla_q;
  assign ctrlB         = ctrlb_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_stat      = rsp_stat_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign busy          = busy_q;
  assign alarm_pending = pending_q;
  assign alarm_irq     = |pending_q;

endmodule
